// File: rtl/elevador_llamadas_pkg.sv
// Shared definitions for the elevator call-conditioning stage.
// Contents: state encoding of the call arbiter, the floor one-hot type and
// constants, and the round-robin pick helper used by the arbiter.
package elevador_llamadas_pkg;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'b00,
      ST_GRANT  = 2'b01,
      ST_MOVING = 2'b10,
      ST_DWELL  = 2'b11
   } state_t;

   // One bit per floor, bit0 = floor 1
   typedef logic [2:0] floor_t;

   localparam floor_t FL_NONE = 3'b000;
   localparam floor_t FL1     = 3'b001;
   localparam floor_t FL2     = 3'b010;
   localparam floor_t FL3     = 3'b100;

   // Next floor upward, wrapping floor 3 back to floor 1
   function automatic floor_t rotl(input floor_t f);
      return {f[1:0], f[2]};
   endfunction

   // First pending floor scanning rr+1, rr+2, rr; FL_NONE when nothing is found
   function automatic floor_t pick(input floor_t pend, input floor_t rr);
      floor_t c1;
      floor_t c2;
      c1 = rotl(rr);
      c2 = rotl(c1);
      if ((pend & c1) != FL_NONE) begin
         pick = c1;
      end else if ((pend & c2) != FL_NONE) begin
         pick = c2;
      end else if ((pend & rr) != FL_NONE) begin
         pick = rr;
      end else begin
         pick = FL_NONE;
      end
   endfunction

endpackage

// File: rtl/elevador_llamadas_if.sv
// Bundle between the call-conditioning stage and its surroundings.
//  p_raw, f_raw : raw call buttons / floor sensors (bit0 = floor 1)
//  mup, mdw     : motor commands coming back from the elevator FSM
//  p1..p3, s    : granted call and inhibit towards the elevator FSM
//  f1..f3       : debounced floor sensors towards the elevator FSM
//  pend         : latched pending calls for the indicator LEDs
// master drives the raw inputs and motor commands; slave is the conditioning stage.
interface elevador_llamadas_if;
   import elevador_llamadas_pkg::*;

   floor_t p_raw;
   floor_t f_raw;
   logic   mup;
   logic   mdw;
   logic   p1;
   logic   p2;
   logic   p3;
   logic   s;
   logic   f1;
   logic   f2;
   logic   f3;
   floor_t pend;

   modport master (
      output p_raw, f_raw, mup, mdw,
      input  p1, p2, p3, s, f1, f2, f3, pend
   );

   modport slave (
      input  p_raw, f_raw, mup, mdw,
      output p1, p2, p3, s, f1, f2, f3, pend
   );

endinterface

// File: rtl/elevador_llamadas_antirrebote.sv
// Single-bit synchroniser plus debouncer.
//  clk   : system clock
//  reset : asynchronous active-low reset, output and counter go to 0
//  din   : raw asynchronous, bouncy input
//  dout  : debounced level; takes the synchronised value once it has been
//          seen DB_CYCLES consecutive cycles different from the current output
// Latency from a clean din edge to dout is DB_CYCLES+2 cycles.
module elevador_llamadas_antirrebote #(
   parameter int DB_CYCLES = 500000,
   parameter int CNT_W     = 23
) (
   input  logic clk,
   input  logic reset,
   input  logic din,
   output logic dout
);

   localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
   localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DB_CYCLES - 1);

   logic [1:0]       sync_r;
   logic [CNT_W-1:0] cnt_r;
   logic             dout_r;

   // Two-flop synchroniser against metastability on the raw input
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         sync_r <= 2'b00;
      end else begin
         sync_r <= {sync_r[0], din};
      end
   end

   // Counts consecutive samples that disagree with the output; any agreeing
   // sample restarts the count, so bounces shorter than DB_CYCLES are dropped
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         cnt_r  <= CNT_ZERO;
         dout_r <= 1'b0;
      end else if (sync_r[1] == dout_r) begin
         cnt_r  <= CNT_ZERO;
      end else if (cnt_r >= CNT_LAST) begin
         cnt_r  <= CNT_ZERO;
         dout_r <= sync_r[1];
      end else begin
         cnt_r  <= cnt_r + CNT_ONE;
      end
   end

   assign dout = dout_r;

endmodule

// File: rtl/elevador_llamadas.sv
// Call-conditioning stage in front of the 3-floor elevator FSM.
// Debounces the call buttons and floor sensors, latches pending calls and
// hands exactly one call at a time to the FSM, with round-robin fairness.
//  clk   : system clock
//  reset : asynchronous active-low reset; drops every pending call
//  bus   : elevador_llamadas_if.slave
//          in  p_raw, f_raw, mup, mdw
//          out p1..p3 (granted call, at most one high), s (1 = FSM ignores p),
//              f1..f3 (debounced sensors), pend (latched calls)
// All outputs are registered. p != 000 only in GRANT/MOVING, where s = 0.
module elevador_llamadas
   import elevador_llamadas_pkg::*;
#(
   parameter int DB_CYCLES    = 500000,
   parameter int DWELL_CYCLES = 2500000,
   parameter int GRANT_TOUT   = 5000000,
   parameter int CNT_W        = 23
) (
   input  logic clk,
   input  logic reset,
   elevador_llamadas_if.slave bus
);

   localparam logic [CNT_W-1:0] CNT_ZERO   = {CNT_W{1'b0}};
   localparam logic [CNT_W-1:0] CNT_ONE    = {{(CNT_W-1){1'b0}}, 1'b1};
   localparam logic [CNT_W-1:0] CNT_MAX    = {CNT_W{1'b1}};
   localparam logic [CNT_W-1:0] TOUT_LAST  = CNT_W'(GRANT_TOUT - 1);
   localparam logic [CNT_W-1:0] DWELL_LAST = CNT_W'(DWELL_CYCLES - 1);

   floor_t           p_db_s;
   floor_t           f_db_s;
   floor_t           p_db_q_r;
   floor_t           here_s;
   floor_t           rise_s;
   floor_t           clr_s;
   floor_t           picked_s;
   logic             parked_s;
   logic             active_s;

   state_t           state_r;
   state_t           state_s;
   floor_t           sel_r;
   floor_t           sel_s;
   floor_t           rr_r;
   floor_t           rr_s;
   floor_t           pend_r;
   floor_t           pend_s;
   logic [CNT_W-1:0] cnt_r;
   logic [CNT_W-1:0] cnt_s;
   logic [CNT_W-1:0] cnt_inc_s;

   floor_t           p_r;
   floor_t           p_s;
   logic             s_r;
   logic             s_s;
   floor_t           f_r;

   for (genvar i = 0; i < 3; i++) begin : g_db
      elevador_llamadas_antirrebote #(
         .DB_CYCLES (DB_CYCLES),
         .CNT_W     (CNT_W)
      ) u_db_p (
         .clk   (clk),
         .reset (reset),
         .din   (bus.p_raw[i]),
         .dout  (p_db_s[i])
      );
      elevador_llamadas_antirrebote #(
         .DB_CYCLES (DB_CYCLES),
         .CNT_W     (CNT_W)
      ) u_db_f (
         .clk   (clk),
         .reset (reset),
         .din   (bus.f_raw[i]),
         .dout  (f_db_s[i])
      );
   end

   // Next-state, pending-call latch and output decode
   always_comb begin
      state_s   = state_r;
      sel_s     = sel_r;
      rr_s      = rr_r;
      cnt_s     = cnt_r;
      picked_s  = pick(pend_r, rr_r);
      parked_s  = ~bus.mup & ~bus.mdw;
      here_s    = parked_s ? f_db_s : FL_NONE;
      rise_s    = p_db_s & ~p_db_q_r;
      active_s  = (state_r == ST_GRANT) || (state_r == ST_MOVING);
      cnt_inc_s = (cnt_r == CNT_MAX) ? cnt_r : (cnt_r + CNT_ONE);

      // A press at the floor the car is parked on is ignored; arrival at the
      // selected floor clears it, and clearing beats a simultaneous press
      if (active_s && ((here_s & sel_r) != FL_NONE)) begin
         clr_s = sel_r;
      end else begin
         clr_s = FL_NONE;
      end
      pend_s = (pend_r | (rise_s & ~here_s)) & ~clr_s;

      case (state_r)
         ST_IDLE: begin
            // picked_s is FL_NONE only if rr_r has lost its one-hot form
            if ((pend_r != FL_NONE) && parked_s && (picked_s != FL_NONE)) begin
               sel_s   = picked_s;
               state_s = ST_GRANT;
               cnt_s   = CNT_ZERO;
            end else begin
               state_s = ST_IDLE;
            end
         end
         ST_GRANT: begin
            // Timeout recovers from an FSM that never answers the grant
            if (bus.mup || bus.mdw) begin
               state_s = ST_MOVING;
            end else if ((here_s & sel_r) != FL_NONE) begin
               state_s = ST_DWELL;
               cnt_s   = CNT_ZERO;
               rr_s    = sel_r;
            end else if (cnt_r == TOUT_LAST) begin
               state_s = ST_IDLE;
            end else begin
               cnt_s   = cnt_inc_s;
            end
         end
         ST_MOVING: begin
            // Stopping away from the selected floor returns the call to arbitration
            if (parked_s) begin
               if ((f_db_s & sel_r) != FL_NONE) begin
                  state_s = ST_DWELL;
                  cnt_s   = CNT_ZERO;
                  rr_s    = sel_r;
               end else begin
                  state_s = ST_IDLE;
               end
            end else begin
               state_s = ST_MOVING;
            end
         end
         ST_DWELL: begin
            if (cnt_r == DWELL_LAST) begin
               state_s = ST_IDLE;
            end else begin
               cnt_s   = cnt_inc_s;
            end
         end
         default: begin
            state_s = ST_IDLE;
            sel_s   = FL_NONE;
            rr_s    = FL1;
            cnt_s   = CNT_ZERO;
         end
      endcase

      if ((state_s == ST_GRANT) || (state_s == ST_MOVING)) begin
         p_s = sel_s;
         s_s = 1'b0;
      end else begin
         p_s = FL_NONE;
         s_s = 1'b1;
      end
   end

   // Arbiter state, latched calls and registered outputs
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_r  <= ST_IDLE;
         sel_r    <= FL_NONE;
         rr_r     <= FL1;
         cnt_r    <= CNT_ZERO;
         pend_r   <= FL_NONE;
         p_db_q_r <= FL_NONE;
         p_r      <= FL_NONE;
         s_r      <= 1'b1;
         f_r      <= FL_NONE;
      end else begin
         state_r  <= state_s;
         sel_r    <= sel_s;
         rr_r     <= rr_s;
         cnt_r    <= cnt_s;
         pend_r   <= pend_s;
         p_db_q_r <= p_db_s;
         p_r      <= p_s;
         s_r      <= s_s;
         f_r      <= f_db_s;
      end
   end

   assign bus.p1   = p_r[0];
   assign bus.p2   = p_r[1];
   assign bus.p3   = p_r[2];
   assign bus.s    = s_r;
   assign bus.f1   = f_r[0];
   assign bus.f2   = f_r[1];
   assign bus.f3   = f_r[2];
   assign bus.pend = pend_r;

endmodule

// File: tb/tb_elevador_llamadas.sv
// Self-checking bench for elevador_llamadas: directed scenarios followed by
// randomized stimulus, all outputs compared each cycle against a behavioural model.
module tb_elevador_llamadas;

   localparam int DB = 4;
   localparam int DW = 8;
   localparam int GT = 16;
   localparam int CW = 5;

   localparam int IDLE   = 0;
   localparam int GRANT  = 1;
   localparam int MOVING = 2;
   localparam int DWELL  = 3;

   logic clk;
   logic reset;
   int   vectors;
   int   miscompares;

   elevador_llamadas_if bus ();

   elevador_llamadas #(
      .DB_CYCLES    (DB),
      .DWELL_CYCLES (DW),
      .GRANT_TOUT   (GT),
      .CNT_W        (CW)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ---------------- behavioural reference model ----------------
   logic [9:0] exp_q[$];         // {p, s, f, pend}
   logic [2:0] praw_h[$];
   logic [2:0] fraw_h[$];
   logic [2:0] m_pdb, m_pdb_prev, m_fdb, m_pend;
   int         m_mode, m_sel, m_rr, m_cnt;

   task automatic model_reset();
      praw_h.delete();
      fraw_h.delete();
      for (int j = 0; j < DB + 2; j++) begin
         praw_h.push_back(3'b000);
         fraw_h.push_back(3'b000);
      end
      m_pdb = 3'b000; m_pdb_prev = 3'b000; m_fdb = 3'b000; m_pend = 3'b000;
      m_mode = IDLE; m_sel = 0; m_rr = 0; m_cnt = 0;
   endtask

   // New debounced level: the raw value seen two cycles ago wins once it has
   // been steady over the last DB samples, otherwise the old level holds
   function automatic logic [2:0] debounce(input logic [2:0] h[$], input logic [2:0] old);
      logic [2:0] r;
      for (int b = 0; b < 3; b++) begin
         bit same;
         same = 1'b1;
         for (int j = 1; j < DB; j++) if (h[j][b] != h[0][b]) same = 1'b0;
         r[b] = same ? h[0][b] : old[b];
      end
      return r;
   endfunction

   task automatic model_step();
      bit         parked;
      logic [2:0] here, rise, np;
      logic [2:0] pexp;
      bit         moving_or_grant;
      parked = !bus.mup && !bus.mdw;
      here   = parked ? m_fdb : 3'b000;
      rise   = m_pdb & ~m_pdb_prev;
      np     = m_pend | (rise & ~here);
      if ((m_mode == GRANT || m_mode == MOVING) && here[m_sel]) np[m_sel] = 1'b0;
      case (m_mode)
         IDLE: if (m_pend != 3'b000 && parked) begin
            for (int k = 3; k >= 1; k--) if (m_pend[(m_rr + k) % 3]) m_sel = (m_rr + k) % 3;
            m_mode = GRANT; m_cnt = 0;
         end
         GRANT: begin
            if (bus.mup || bus.mdw) m_mode = MOVING;
            else if (here[m_sel]) begin m_mode = DWELL; m_cnt = 0; m_rr = m_sel; end
            else if (m_cnt == GT - 1) m_mode = IDLE;
            else m_cnt++;
         end
         MOVING: if (parked) begin
            if (m_fdb[m_sel]) begin m_mode = DWELL; m_cnt = 0; m_rr = m_sel; end
            else m_mode = IDLE;
         end
         default: begin
            if (m_cnt == DW - 1) m_mode = IDLE;
            else m_cnt++;
         end
      endcase
      m_pend = np;
      moving_or_grant = (m_mode == GRANT || m_mode == MOVING);
      pexp = moving_or_grant ? (3'b001 << m_sel) : 3'b000;
      exp_q.push_back({pexp, !moving_or_grant, m_fdb, m_pend});
      praw_h.push_back(bus.p_raw); void'(praw_h.pop_front());
      fraw_h.push_back(bus.f_raw); void'(fraw_h.pop_front());
      m_pdb_prev = m_pdb;
      m_pdb = debounce(praw_h, m_pdb);
      m_fdb = debounce(fraw_h, m_fdb);
   endtask

   // Model advances on every DUT clock; reset flushes pending expectations
   always @(posedge clk or negedge reset) begin
      if (!reset) begin
         model_reset();
         exp_q.delete();
         exp_q.push_back({3'b000, 1'b1, 3'b000, 3'b000});
      end else begin
         model_step();
      end
   end

   // Monitor: compares each cycle's outputs with the oldest expectation
   always @(negedge clk) begin
      if (exp_q.size() != 0) begin
         logic [9:0] e, g;
         e = exp_q.pop_front();
         g = {bus.p3, bus.p2, bus.p1, bus.s, bus.f3, bus.f2, bus.f1, bus.pend};
         vectors++;
         if (g !== e) begin
            miscompares++;
            $display("FAIL scoreboard t=%0t got p=%b s=%b f=%b pend=%b want p=%b s=%b f=%b pend=%b",
                     $time, g[9:7], g[6], g[5:3], g[2:0], e[9:7], e[6], e[5:3], e[2:0]);
         end
      end
   end

   // ---------------- stimulus helpers ----------------
   function automatic logic [2:0] p_out();
      return {bus.p3, bus.p2, bus.p1};
   endfunction

   task automatic chk(input string name, input int got, input int want);
      vectors++;
      if (got != want) begin
         miscompares++;
         $display("FAIL %s got=%0d want=%0d t=%0t", name, got, want, $time);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic wait_p(input logic [2:0] want, input int budget, input string name);
      int n;
      n = 0;
      while (p_out() != want && n < budget) begin
         @(negedge clk);
         n++;
      end
      chk(name, int'(p_out()), int'(want));
   endtask

   task automatic do_reset();
      @(negedge clk); #1;
      reset = 1'b0;
      bus.p_raw = 3'b000; bus.f_raw = 3'b000; bus.mup = 1'b0; bus.mdw = 1'b0;
      tick(3);
      @(negedge clk); #1;
      reset = 1'b1;
   endtask

   initial begin
      #900000;
      $display("FAIL watchdog expired t=%0t", $time);
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      vectors = 0; miscompares = 0;
      reset = 1'b0;
      bus.p_raw = 3'b000; bus.f_raw = 3'b000; bus.mup = 1'b0; bus.mdw = 1'b0;
      tick(3);
      chk("reset_p", int'(p_out()), 0);
      chk("reset_s", int'(bus.s), 1);
      chk("reset_f", int'({bus.f3, bus.f2, bus.f1}), 0);
      chk("reset_pend", int'(bus.pend), 0);
      @(negedge clk); #1 reset = 1'b1;

      // Bounce: only the final steady press gets through
      for (int i = 0; i < 5; i++) begin
         bus.p_raw = 3'b010; tick(2);
         bus.p_raw = 3'b000; tick(2);
      end
      bus.p_raw = 3'b010;
      n = 0;
      do begin @(negedge clk); n++; end while (bus.pend != 3'b010 && n < 20);
      chk("bounce_latency", n, DB + 3);

      // Same-floor press is ignored
      do_reset();
      bus.f_raw = 3'b001; tick(8);
      bus.p_raw = 3'b001; tick(10);
      bus.p_raw = 3'b000; tick(10);
      chk("same_floor_pend", int'(bus.pend), 0);
      chk("same_floor_p", int'(p_out()), 0);
      chk("same_floor_s", int'(bus.s), 1);

      // Trip floor1 -> floor3
      do_reset();
      bus.f_raw = 3'b001; tick(8);
      bus.p_raw = 3'b100; tick(10);
      bus.p_raw = 3'b000;
      wait_p(3'b100, 30, "trip_grant");
      chk("trip_grant_s", int'(bus.s), 0);
      bus.mup = 1'b1; bus.f_raw = 3'b000; tick(10);
      bus.f_raw = 3'b100; tick(10);
      bus.mup = 1'b0;
      wait_p(3'b000, 5, "trip_arrive_p");
      chk("trip_arrive_s", int'(bus.s), 1);
      chk("trip_arrive_pend", int'(bus.pend), 0);
      tick(12);

      // Fairness: rr at floor2 with floors 1 and 3 pending
      do_reset();
      bus.f_raw = 3'b001; tick(8);
      bus.p_raw = 3'b010; tick(10);
      bus.p_raw = 3'b000;
      wait_p(3'b010, 30, "fair_setup");
      bus.mup = 1'b1; bus.f_raw = 3'b000; bus.p_raw = 3'b101; tick(10);
      bus.p_raw = 3'b000; bus.f_raw = 3'b010; tick(8);
      bus.mup = 1'b0;
      wait_p(3'b000, 5, "fair_arrive2");
      chk("fair_pend", int'(bus.pend), 5);
      wait_p(3'b100, 40, "fair_first_floor3");
      bus.mup = 1'b1; bus.f_raw = 3'b100; tick(10);
      bus.mup = 1'b0;
      wait_p(3'b000, 5, "fair_arrive3");
      wait_p(3'b001, 40, "fair_then_floor1");

      // Grant timeout with no motor response, then regrant
      do_reset();
      bus.p_raw = 3'b010;
      wait_p(3'b010, 30, "tout_grant");
      n = 0;
      while (p_out() == 3'b010 && n < 40) begin
         n++;
         @(negedge clk);
      end
      chk("tout_len", n, GT);
      chk("tout_p_drop", int'(p_out()), 0);
      chk("tout_pend_kept", int'(bus.pend), 2);
      @(negedge clk);
      chk("tout_regrant", int'(p_out()), 2);

      // Asynchronous reset in the middle of a trip
      do_reset();
      bus.f_raw = 3'b001; tick(8);
      bus.p_raw = 3'b100; tick(10);
      bus.p_raw = 3'b000;
      wait_p(3'b100, 30, "areset_grant");
      bus.mup = 1'b1; tick(3);
      @(posedge clk); #2;
      reset = 1'b0;
      #1;
      chk("areset_p", int'(p_out()), 0);
      chk("areset_s", int'(bus.s), 1);
      chk("areset_pend", int'(bus.pend), 0);
      bus.mup = 1'b0; bus.f_raw = 3'b000;
      tick(2);
      @(negedge clk); #1 reset = 1'b1;

      // Randomized traffic
      for (int it = 0; it < 300; it++) begin
         int r;
         r = $urandom_range(0, 9);
         case (r)
            0, 1, 2: bus.p_raw = 3'($urandom_range(0, 7));
            3:       bus.p_raw = 3'b000;
            4, 5: begin
               int fl;
               fl = $urandom_range(0, 3);
               bus.f_raw = (fl == 3) ? 3'b000 : (3'b001 << fl);
            end
            6, 7: begin
               int m;
               m = $urandom_range(0, 2);
               bus.mup = (m == 1);
               bus.mdw = (m == 2);
            end
            8: begin
               int b;
               b = $urandom_range(0, 2);
               for (int k = 0; k < 6; k++) begin
                  bus.p_raw[b] = ~bus.p_raw[b];
                  tick(1);
               end
            end
            default: begin bus.mup = 1'b0; bus.mdw = 1'b0; end
         endcase
         if ($urandom_range(0, 60) == 0) do_reset();
         tick($urandom_range(1, 12));
      end
      tick(4);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
